spi_reg_bridge: RTL and testbench
=================================

SPI_REG_BRIDGE -- requirements
Module: spi_reg_bridge

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flops per SPI-domain input, legal range 2..3.
REQ-002 Parameter TURNAROUND_BYTE, default 8'h00: value shifted out during data byte 1 of a read frame.
REQ-003 iCLK  input  1  system clock; the only clock; all flops on rising edge.
REQ-004 iRST  input  1  reset, asynchronous, active-high.
REQ-005 iSPI_SS_n  input  1  slave select from SPI slave, active-low, asynchronous to iCLK.
REQ-006 iSPI_CMD  input  8  latched command: [7]=write, [6:3]=peripheral, [2:0]=start offset.
REQ-007 iSPI_BYTE  input  8  received data byte.
REQ-008 iSPI_WRITE_SIG  input  1  end-of-data-byte strobe for write frames, asynchronous.
REQ-009 iSPI_READ_SIG  input  1  start-of-byte strobe, asynchronous.
REQ-010 iSPI_INC_RDADDR  input  1  end-of-data-byte strobe, asynchronous.
REQ-011 oSPI_SEND_BYTE  output  8  byte presented to the SPI slave for shifting out.
REQ-012 oBUS_ADDR  output  8  {peripheral[3:0], offset[3:0]}.
REQ-013 oBUS_WDATA  output  8  write data.
REQ-014 oBUS_WR  output  1  one-cycle write strobe.
REQ-015 oBUS_RD  output  1  one-cycle read strobe.
REQ-016 iBUS_RDATA  input  8  read data, valid exactly one cycle after oBUS_RD.
REQ-017 oFRAME_ACTIVE  output  1  high in states HDR and DATA.
REQ-018 oERR_SHORT  output  1  sticky: frame ended before its command was latched.

Function
REQ-019 Each asynchronous input SHALL pass SYNC_STAGES flops, then a rising-edge detector producing a one-cycle event.
REQ-020 The SPI clock SHALL be at most iCLK/8; the bridge is not required to behave correctly above this ratio.
REQ-021 States SHALL be IDLE, HDR, DATA; on leaving reset, state = IDLE.
REQ-022 IDLE->HDR on synchronized SS_n fall: offset<=0, READ-edge count<=0, oSPI_SEND_BYTE<=TURNAROUND_BYTE.
REQ-023 In HDR, READ edge #1 SHALL be ignored; READ edge #2 SHALL latch iSPI_CMD, set offset={1'b0,CMD[2:0]}, and move to DATA.
REQ-024 On entering DATA with CMD[7]=0, the bridge SHALL pulse oBUS_RD at {periph,offset} and capture iBUS_RDATA into the prefetch register one cycle later.
REQ-025 In a read frame, each INC_RDADDR edge SHALL load oSPI_SEND_BYTE<=prefetch, increment offset, and issue the next oBUS_RD; byte N>=2 returns reg[start+N-2].
REQ-026 In a write frame, each WRITE_SIG edge SHALL sample iSPI_BYTE into oBUS_WDATA, pulse oBUS_WR at the current address, then increment offset.
REQ-027 Offset SHALL be 4 bits and wrap from 15 to 0; the peripheral field does not change within a frame.
REQ-028 WRITE_SIG edges in read frames, and INC_RDADDR edges in write frames, SHALL be ignored.
REQ-029 At most one bus strobe SHALL be asserted per cycle; oBUS_WR and oBUS_RD are never high together.
REQ-030 A synchronized SS_n rise in HDR or DATA SHALL return to IDLE next cycle; a pending prefetch capture SHALL be discarded.
REQ-031 A strobe edge and an SS_n rise in the same cycle SHALL process the strobe first, then abort.
REQ-032 An SS_n rise in HDR SHALL set oERR_SHORT; the next command latch SHALL clear it.
REQ-033 oBUS_ADDR and oBUS_WDATA SHALL hold their last values between strobes.

Reset
REQ-034 iRST SHALL asynchronously clear all synchronizer flops, the state (to IDLE), offset, the command and prefetch registers, oBUS_ADDR, oBUS_WDATA, oBUS_WR, oBUS_RD, oFRAME_ACTIVE and oERR_SHORT.
REQ-035 On iRST, oSPI_SEND_BYTE SHALL take TURNAROUND_BYTE.
REQ-036 Reset asserted mid-frame SHALL abort without any bus strobe; after release, the bridge waits in IDLE for a new SS_n fall.

Structure
REQ-037 Package spi_bridge_pkg SHALL hold the state enumeration, the address, offset and peripheral widths, and the command bit positions.
REQ-038 Sub-module spi_sync_edge (SYNC_STAGES synchronizer plus rising-edge pulse) SHALL be instantiated once per asynchronous input (4 instances).

Verification
REQ-039 Write frame: cmd 0x9A (periph 3, offset 2), bytes 0x11, 0x22 -> oBUS_WR at addr 0x32 data 0x11, then at 0x33 data 0x22.
REQ-040 Read frame: cmd 0x1D (periph 3, offset 5), three data bytes -> oSPI_SEND_BYTE = 0x00, reg[0x35], reg[0x36] in turn; oBUS_RD at 0x35, 0x36, 0x37.
REQ-041 Wrap: write cmd 0x87 (offset 7), eleven bytes -> addresses 0x07..0x0F, then 0x00, 0x01.
REQ-042 Short frame: SS_n low for 4 SPI clocks, then high -> oERR_SHORT=1, no bus strobes; the next valid frame clears it.
REQ-043 Abort: iRST pulse after 3 bytes of a write frame -> all outputs at reset values, no further oBUS_WR until a new frame.
REQ-044 Same-cycle event: WRITE_SIG edge coincident with synchronized SS_n rise -> the write completes, then state = IDLE.

Source files
------------

// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and field positions for the SPI-to-register bridge.
package spi_bridge_pkg;

  localparam int ADDR_W   = 8;
  localparam int OFFSET_W = 4;
  localparam int PERIPH_W = 4;

  // Command byte layout: [7]=write, [6:3]=peripheral, [2:0]=start offset
  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_PERIPH_HI = 6;
  localparam int CMD_PERIPH_LO = 3;
  localparam int CMD_OFFSET_HI = 2;
  localparam int CMD_OFFSET_LO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } stateT;

  function automatic logic [ADDR_W-1:0] busAddr(input logic [PERIPH_W-1:0] periph,
                                                input logic [OFFSET_W-1:0] offset);
    return {periph, offset};
  endfunction

endpackage

// File: rtl/spi_reg_bridge_if.sv
// SPI-slave side and register-bus side signals of the bridge.
interface spi_reg_bridge_if;
  import spi_bridge_pkg::*;

  logic                iSPI_SS_n;
  logic [7:0]          iSPI_CMD;
  logic [7:0]          iSPI_BYTE;
  logic                iSPI_WRITE_SIG;
  logic                iSPI_READ_SIG;
  logic                iSPI_INC_RDADDR;
  logic [7:0]          oSPI_SEND_BYTE;
  logic [ADDR_W-1:0]   oBUS_ADDR;
  logic [7:0]          oBUS_WDATA;
  logic                oBUS_WR;
  logic                oBUS_RD;
  logic [7:0]          iBUS_RDATA;
  logic                oFRAME_ACTIVE;
  logic                oERR_SHORT;

  // Bridge view: it is the master of the register bus.
  modport master (
    input  iSPI_SS_n, iSPI_CMD, iSPI_BYTE, iSPI_WRITE_SIG, iSPI_READ_SIG,
           iSPI_INC_RDADDR, iBUS_RDATA,
    output oSPI_SEND_BYTE, oBUS_ADDR, oBUS_WDATA, oBUS_WR, oBUS_RD,
           oFRAME_ACTIVE, oERR_SHORT
  );

  // Environment view: SPI slave core plus register file.
  modport slave (
    output iSPI_SS_n, iSPI_CMD, iSPI_BYTE, iSPI_WRITE_SIG, iSPI_READ_SIG,
           iSPI_INC_RDADDR, iBUS_RDATA,
    input  oSPI_SEND_BYTE, oBUS_ADDR, oBUS_WDATA, oBUS_WR, oBUS_RD,
           oFRAME_ACTIVE, oERR_SHORT
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer followed by a one-cycle edge detector.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iASYNC,
  output logic oRISE,
  output logic oFALL
);

  logic [STAGES-1:0] syncQ;
  logic              prevQ;

  // Shift the async input through the synchronizer and keep one cycle of history.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      syncQ <= '0;
      prevQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[STAGES-2:0], iASYNC};
      prevQ <= syncQ[STAGES-1];
    end
  end

  assign oRISE = syncQ[STAGES-1] & ~prevQ;
  assign oFALL = ~syncQ[STAGES-1] & prevQ;

endmodule

// File: rtl/spi_reg_bridge.sv
// Bridges SPI frames (command byte + data bytes) onto a simple register bus.
//
//   state | meaning
//   IDLE  | waiting for slave select to fall
//   HDR   | frame open, waiting for the command byte
//   DATA  | command latched, moving data bytes
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int         SYNC_STAGES     = 2,
  parameter logic [7:0] TURNAROUND_BYTE = 8'h00
) (
  input  logic iCLK,
  input  logic iRST,
  spi_reg_bridge_if.master bus
);

  logic ssRise, ssFall, wrEv, rdEv, incEv;
  logic wrFall, rdFall, incFall;
  logic unusedFalls;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) uSyncSs (
    .iCLK(iCLK), .iRST(iRST), .iASYNC(bus.iSPI_SS_n), .oRISE(ssRise), .oFALL(ssFall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) uSyncWr (
    .iCLK(iCLK), .iRST(iRST), .iASYNC(bus.iSPI_WRITE_SIG), .oRISE(wrEv), .oFALL(wrFall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) uSyncRd (
    .iCLK(iCLK), .iRST(iRST), .iASYNC(bus.iSPI_READ_SIG), .oRISE(rdEv), .oFALL(rdFall));
  spi_sync_edge #(.STAGES(SYNC_STAGES)) uSyncInc (
    .iCLK(iCLK), .iRST(iRST), .iASYNC(bus.iSPI_INC_RDADDR), .oRISE(incEv), .oFALL(incFall));

  // Only the slave-select falling edge is of interest.
  assign unusedFalls = wrFall | rdFall | incFall;

  stateT                state, stateNext;
  logic [OFFSET_W-1:0]  offset;
  logic [PERIPH_W-1:0]  cmdPeriph;
  logic                 cmdWrite;
  logic                 rdEdgeSeen;
  logic [7:0]           prefetch;
  logic                 rdPend;
  logic [ADDR_W-1:0]    addrQ;
  logic [7:0]           wdataQ, sendQ;
  logic                 wrQ, rdQ, errQ;
  logic                 latchCmd, doWrite, doInc;
  logic [OFFSET_W-1:0]  startOffset;
  logic [OFFSET_W-1:0]  offsetInc;

  assign startOffset = {1'b0, bus.iSPI_CMD[CMD_OFFSET_HI:CMD_OFFSET_LO]};
  assign offsetInc   = offset + 4'd1;

  // State register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  // Next state and per-cycle actions; a strobe in the same cycle as an SS rise still acts.
  always_comb begin
    stateNext = state;
    latchCmd  = 1'b0;
    doWrite   = 1'b0;
    doInc     = 1'b0;
    case (state)
      IDLE: if (ssFall) stateNext = HDR;
      HDR: begin
        latchCmd = rdEv & rdEdgeSeen;
        if (ssRise)        stateNext = IDLE;
        else if (latchCmd) stateNext = DATA;
      end
      DATA: begin
        doWrite = wrEv & cmdWrite;
        doInc   = incEv & ~cmdWrite;
        if (ssRise) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Frame datapath: offset tracking, command capture, bus strobes and prefetch.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      offset     <= '0;
      cmdPeriph  <= '0;
      cmdWrite   <= 1'b0;
      rdEdgeSeen <= 1'b0;
      prefetch   <= '0;
      rdPend     <= 1'b0;
      addrQ      <= '0;
      wdataQ     <= '0;
      sendQ      <= TURNAROUND_BYTE;
      wrQ        <= 1'b0;
      rdQ        <= 1'b0;
      errQ       <= 1'b0;
    end else begin
      wrQ    <= 1'b0;
      rdQ    <= 1'b0;
      rdPend <= rdQ;
      // Read data trails the strobe by one cycle; drop it if the frame is closing.
      if (rdPend && state == DATA && !ssRise) prefetch <= bus.iBUS_RDATA;

      if (state == IDLE && ssFall) begin
        offset     <= '0;
        rdEdgeSeen <= 1'b0;
        sendQ      <= TURNAROUND_BYTE;
      end

      if (state == HDR) begin
        if (rdEv && !rdEdgeSeen) rdEdgeSeen <= 1'b1;
        if (latchCmd) begin
          cmdWrite  <= bus.iSPI_CMD[CMD_WRITE_BIT];
          cmdPeriph <= bus.iSPI_CMD[CMD_PERIPH_HI:CMD_PERIPH_LO];
          offset    <= startOffset;
          errQ      <= 1'b0;
          if (!bus.iSPI_CMD[CMD_WRITE_BIT] && !ssRise) begin
            rdQ   <= 1'b1;
            addrQ <= busAddr(bus.iSPI_CMD[CMD_PERIPH_HI:CMD_PERIPH_LO], startOffset);
          end
        end else if (ssRise) begin
          errQ <= 1'b1;
        end
      end

      if (doWrite) begin
        wdataQ <= bus.iSPI_BYTE;
        wrQ    <= 1'b1;
        addrQ  <= busAddr(cmdPeriph, offset);
        offset <= offsetInc;
      end

      if (doInc) begin
        sendQ  <= prefetch;
        rdQ    <= 1'b1;
        addrQ  <= busAddr(cmdPeriph, offsetInc);
        offset <= offsetInc;
      end
    end
  end

  assign bus.oSPI_SEND_BYTE = sendQ;
  assign bus.oBUS_ADDR      = addrQ;
  assign bus.oBUS_WDATA     = wdataQ;
  assign bus.oBUS_WR        = wrQ;
  assign bus.oBUS_RD        = rdQ;
  assign bus.oFRAME_ACTIVE  = (state != IDLE);
  assign bus.oERR_SHORT     = errQ;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: vector table plus corner-case sequences.
module tb_spi_reg_bridge;

  typedef struct {
    logic       isWr;
    logic [7:0] addr;
    logic [7:0] data;
  } txnT;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] a0;
    logic [7:0] a1;
  } vecT;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  int   checks = 0;
  int   failures = 0;
  txnT  expQ[$];
  logic [7:0] mem [256];
  vecT  vecs [6];

  spi_reg_bridge_if ifc ();

  spi_reg_bridge dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (ifc.master)
  );

  always #5 iCLK = ~iCLK;

  // Register file model: read data valid one cycle after the read strobe.
  always @(posedge iCLK) begin
    if (ifc.oBUS_RD) ifc.iBUS_RDATA <= mem[ifc.oBUS_ADDR];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Bus monitor: every strobe must match the head of the expectation queue.
  always @(negedge iCLK) begin
    if (!iRST && (ifc.oBUS_WR || ifc.oBUS_RD)) begin
      check("wr_rd_exclusive", {31'd0, ifc.oBUS_WR & ifc.oBUS_RD}, 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_strobe actual wr=%0d rd=%0d addr=%02h expected none",
                 ifc.oBUS_WR, ifc.oBUS_RD, ifc.oBUS_ADDR);
      end else begin
        txnT t;
        t = expQ.pop_front();
        check("strobe_kind", {31'd0, ifc.oBUS_WR}, {31'd0, t.isWr});
        check("strobe_addr", {24'd0, ifc.oBUS_ADDR}, {24'd0, t.addr});
        if (t.isWr) check("strobe_wdata", {24'd0, ifc.oBUS_WDATA}, {24'd0, t.data});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      0: ifc.iSPI_WRITE_SIG  = 1'b1;
      1: ifc.iSPI_READ_SIG   = 1'b1;
      default: ifc.iSPI_INC_RDADDR = 1'b1;
    endcase
    tick(4);
    ifc.iSPI_WRITE_SIG  = 1'b0;
    ifc.iSPI_READ_SIG   = 1'b0;
    ifc.iSPI_INC_RDADDR = 1'b0;
    tick(4);
  endtask

  task automatic ssLow();
    ifc.iSPI_SS_n = 1'b0;
    tick(6);
  endtask

  task automatic ssHigh();
    ifc.iSPI_SS_n = 1'b1;
    tick(6);
  endtask

  task automatic header(input logic [7:0] cmd);
    ifc.iSPI_CMD = 8'hEE;
    pulse(1);
    ifc.iSPI_CMD = cmd;
    pulse(1);
  endtask

  task automatic pushTxn(input logic isWr, input logic [7:0] addr, input logic [7:0] data);
    txnT t;
    t.isWr = isWr;
    t.addr = addr;
    t.data = data;
    expQ.push_back(t);
  endtask

  task automatic writeByte(input logic [7:0] addr, input logic [7:0] data);
    pushTxn(1'b1, addr, data);
    ifc.iSPI_BYTE = data;
    pulse(0);
  endtask

  initial begin
    logic [7:0] a2;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5C;

    vecs[0] = '{cmd: 8'h9A, d0: 8'h11, d1: 8'h22, a0: 8'h32, a1: 8'h33};
    vecs[1] = '{cmd: 8'hFF, d0: 8'h5A, d1: 8'hC3, a0: 8'hF7, a1: 8'hF8};
    vecs[2] = '{cmd: 8'h80, d0: 8'hFF, d1: 8'h00, a0: 8'h00, a1: 8'h01};
    vecs[3] = '{cmd: 8'h1D, d0: 8'h00, d1: 8'h00, a0: 8'h35, a1: 8'h36};
    vecs[4] = '{cmd: 8'h7A, d0: 8'h00, d1: 8'h00, a0: 8'hF2, a1: 8'hF3};
    vecs[5] = '{cmd: 8'h40, d0: 8'h00, d1: 8'h00, a0: 8'h80, a1: 8'h81};

    ifc.iSPI_SS_n       = 1'b1;
    ifc.iSPI_CMD        = 8'h00;
    ifc.iSPI_BYTE       = 8'h00;
    ifc.iSPI_WRITE_SIG  = 1'b0;
    ifc.iSPI_READ_SIG   = 1'b0;
    ifc.iSPI_INC_RDADDR = 1'b0;
    tick(3);
    check("rst_send_byte", {24'd0, ifc.oSPI_SEND_BYTE}, 32'h00);
    check("rst_addr",      {24'd0, ifc.oBUS_ADDR}, 32'h00);
    check("rst_frame",     {31'd0, ifc.oFRAME_ACTIVE}, 32'd0);
    check("rst_err",       {31'd0, ifc.oERR_SHORT}, 32'd0);
    iRST = 1'b0;
    tick(6);

    // Table-driven frames: two data bytes each, write or read.
    for (int v = 0; v < 6; v++) begin
      ssLow();
      check("frame_active", {31'd0, ifc.oFRAME_ACTIVE}, 32'd1);
      if (vecs[v].cmd[7]) begin
        header(vecs[v].cmd);
        writeByte(vecs[v].a0, vecs[v].d0);
        pulse(2);
        writeByte(vecs[v].a1, vecs[v].d1);
        check("wdata_hold", {24'd0, ifc.oBUS_WDATA}, {24'd0, vecs[v].d1});
        check("addr_hold",  {24'd0, ifc.oBUS_ADDR}, {24'd0, vecs[v].a1});
      end else begin
        pushTxn(1'b0, vecs[v].a0, 8'h00);
        header(vecs[v].cmd);
        check("rd_byte1", {24'd0, ifc.oSPI_SEND_BYTE}, 32'h00);
        pushTxn(1'b0, vecs[v].a1, 8'h00);
        pulse(2);
        check("rd_byte2", {24'd0, ifc.oSPI_SEND_BYTE}, {24'd0, mem[vecs[v].a0]});
        ifc.iSPI_BYTE = 8'h99;
        pulse(0);
        a2 = {vecs[v].a1[7:4], vecs[v].a1[3:0] + 4'd1};
        pushTxn(1'b0, a2, 8'h00);
        pulse(2);
        check("rd_byte3", {24'd0, ifc.oSPI_SEND_BYTE}, {24'd0, mem[vecs[v].a1]});
      end
      ssHigh();
      check("frame_done", {31'd0, ifc.oFRAME_ACTIVE}, 32'd0);
      check("queue_drained", expQ.size(), 32'd0);
    end

    // Offset wrap within one write frame.
    ssLow();
    header(8'h87);
    for (int i = 0; i < 11; i++) writeByte({4'h0, 4'(7 + i)}, 8'h40 + 8'(i));
    ssHigh();
    check("wrap_drained", expQ.size(), 32'd0);

    // Short frame: closes before the command byte.
    ssLow();
    pulse(1);
    ssHigh();
    check("short_err_set", {31'd0, ifc.oERR_SHORT}, 32'd1);
    check("short_frame_idle", {31'd0, ifc.oFRAME_ACTIVE}, 32'd0);
    ssLow();
    check("short_err_sticky", {31'd0, ifc.oERR_SHORT}, 32'd1);
    header(8'hC8);
    check("short_err_clear", {31'd0, ifc.oERR_SHORT}, 32'd0);
    writeByte(8'h90, 8'h3C);
    ssHigh();

    // Reset in the middle of a write frame.
    ssLow();
    header(8'hA0);
    writeByte(8'h40, 8'h01);
    writeByte(8'h41, 8'h02);
    writeByte(8'h42, 8'h03);
    iRST = 1'b1;
    tick(3);
    check("abort_addr",  {24'd0, ifc.oBUS_ADDR}, 32'h00);
    check("abort_wdata", {24'd0, ifc.oBUS_WDATA}, 32'h00);
    check("abort_send",  {24'd0, ifc.oSPI_SEND_BYTE}, 32'h00);
    check("abort_frame", {31'd0, ifc.oFRAME_ACTIVE}, 32'd0);
    check("abort_wr",    {31'd0, ifc.oBUS_WR}, 32'd0);
    iRST = 1'b0;
    tick(4);
    ifc.iSPI_BYTE = 8'h04;
    pulse(0);
    check("abort_stays_idle", {31'd0, ifc.oFRAME_ACTIVE}, 32'd0);
    ssHigh();
    ssLow();
    header(8'hA0);
    writeByte(8'h40, 8'h05);
    ssHigh();

    // Write strobe and slave-select rise in the same cycle.
    ssLow();
    header(8'hC8);
    pushTxn(1'b1, 8'h90, 8'h77);
    ifc.iSPI_BYTE      = 8'h77;
    ifc.iSPI_WRITE_SIG = 1'b1;
    ifc.iSPI_SS_n      = 1'b1;
    tick(6);
    check("same_cycle_idle", {31'd0, ifc.oFRAME_ACTIVE}, 32'd0);
    check("same_cycle_wdata", {24'd0, ifc.oBUS_WDATA}, 32'h77);
    ifc.iSPI_WRITE_SIG = 1'b0;
    tick(6);

    check("final_drained", expQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
